// File: rtl/kbd_pkg.sv
// Shared scan-code constants, parser state encoding and event record for the keyboard event path.
// KBD_EXT_EN adds the extended-prefix parser states.
package kbd_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

`ifdef KBD_EXT_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } kbd_state_e;
`else
    typedef enum logic [0:0] {
        ST_IDLE,
        ST_BRK
    } kbd_state_e;
`endif

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

endpackage

// File: rtl/kbd_event_ctrl_if.sv
// Key-event handshake between kbd_event_ctrl (master) and its downstream consumer (slave).
interface kbd_event_ctrl_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_break;
    logic       evt_ext;

    modport master (output evt_valid, evt_code, evt_break, evt_ext, input evt_ready);
    modport slave  (input evt_valid, evt_code, evt_break, evt_ext, output evt_ready);
endinterface

// File: rtl/kbd_evt_fifo.sv
// First-word-fall-through synchronous FIFO; a pop frees a slot for a push in the same cycle.
module kbd_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is data only; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/kbd_event_ctrl.sv
// Turns the PS/2 scan-code byte stream into queued make/break events and tracks the held key.
// Define KBD_EXT_EN to decode the E0 extended prefix; otherwise E0 bytes are swallowed.
module kbd_event_ctrl
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    kbd_event_ctrl_if.master     evt,
    output logic                 key_down,
    output logic [7:0]           held_code,
    output logic                 held_ext,
    output logic [CNT_W-1:0]     press_count,
    output logic                 overflow
);
    kbd_state_e state, state_nx;
    logic       emit;
    evt_t       ev;
    evt_t       head;
    logic       match;
    logic       fifo_full;
    logic       fifo_empty;

    always_comb begin
        state_nx = state;
        emit     = 1'b0;
        ev.ext   = 1'b0;
        ev.brk   = 1'b0;
        ev.code  = byte_data;
        if (byte_valid) begin
            case (state)
                ST_IDLE: begin
                    if (byte_data == SC_BREAK) state_nx = ST_BRK;
`ifdef KBD_EXT_EN
                    else if (byte_data == SC_EXT) state_nx = ST_EXT;
`else
                    else if (byte_data == SC_EXT) state_nx = state;
`endif
                    else emit = 1'b1;
                end
                ST_BRK: begin
                    // An E0 here abandons the pending break.
                    if (byte_data == SC_BREAK) state_nx = ST_BRK;
`ifdef KBD_EXT_EN
                    else if (byte_data == SC_EXT) state_nx = ST_EXT;
`else
                    else if (byte_data == SC_EXT) state_nx = state;
`endif
                    else begin
                        emit     = 1'b1;
                        ev.brk   = 1'b1;
                        state_nx = ST_IDLE;
                    end
                end
`ifdef KBD_EXT_EN
                ST_EXT: begin
                    if (byte_data == SC_BREAK) state_nx = ST_EXT_BRK;
                    else if (byte_data == SC_EXT) state_nx = ST_EXT;
                    else begin
                        emit     = 1'b1;
                        ev.ext   = 1'b1;
                        state_nx = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    if (byte_data == SC_BREAK) state_nx = ST_EXT_BRK;
                    else if (byte_data == SC_EXT) state_nx = ST_EXT;
                    else begin
                        emit     = 1'b1;
                        ev.ext   = 1'b1;
                        ev.brk   = 1'b1;
                        state_nx = ST_IDLE;
                    end
                end
`endif
                default: state_nx = ST_IDLE;
            endcase
        end
    end

`ifdef KBD_EXT_EN
    assign match = ({ev.ext, ev.code} == {held_ext, held_code});
`else
    assign match = (ev.code == held_code);
    assign held_ext = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            key_down    <= 1'b0;
            held_code   <= '0;
`ifdef KBD_EXT_EN
            held_ext    <= 1'b0;
`endif
            press_count <= '0;
            overflow    <= 1'b0;
        end else begin
            state <= state_nx;
            if (emit) begin
                if (!ev.brk) begin
                    // A make matching the held key is typematic repeat and leaves tracking alone.
                    if (!key_down || !match) begin
                        press_count <= press_count + 1'b1;
                        key_down    <= 1'b1;
                        held_code   <= ev.code;
`ifdef KBD_EXT_EN
                        held_ext    <= ev.ext;
`endif
                    end
                end else if (key_down && match) begin
                    key_down <= 1'b0;
                end
            end
            if (emit && fifo_full && !evt.evt_ready) overflow <= 1'b1;
        end
    end

    kbd_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(evt_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (emit),
        .push_data (ev),
        .full      (fifo_full),
        .pop       (evt.evt_ready),
        .empty     (fifo_empty),
        .head      (head)
    );

    assign evt.evt_valid = ~fifo_empty;
    assign evt.evt_code  = fifo_empty ? 8'h00 : head.code;
    assign evt.evt_break = fifo_empty ? 1'b0  : head.brk;
    assign evt.evt_ext   = fifo_empty ? 1'b0  : head.ext;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Scoreboard bench for kbd_event_ctrl: expected events are queued as bytes are driven and
// compared as the consumer accepts them; status outputs are checked after each completing byte.
module tb_kbd_event_ctrl;
    import kbd_pkg::*;

    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 8;
`ifdef KBD_EXT_EN
    localparam logic EXT_ON = 1'b1;
`else
    localparam logic EXT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             byte_valid = 1'b0;
    logic [7:0]       byte_data = 8'h00;
    logic             key_down;
    logic [7:0]       held_code;
    logic             held_ext;
    logic [CNT_W-1:0] press_count;
    logic             overflow;

    int checks = 0;
    int errors = 0;
    logic [9:0] sb [$];
    logic [9:0] exp_e;

    kbd_event_ctrl_if evt_if ();

    kbd_event_ctrl #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .evt         (evt_if.master),
        .key_down    (key_down),
        .held_code   (held_code),
        .held_ext    (held_ext),
        .press_count (press_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_evt(input logic [7:0] code, input logic brk, input logic ext);
        sb.push_back({ext, brk, code});
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        byte_valid = 1'b0;
        evt_if.evt_ready = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        evt_if.evt_ready = 1'b1;
        for (int i = 0; i < 32 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        chk({tag, "_left"}, sb.size(), 0);
        chk({tag, "_valid"}, evt_if.evt_valid, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && evt_if.evt_valid && evt_if.evt_ready) begin
            if (sb.size() == 0) begin
                chk("evt_unexpected_sbsize", sb.size(), 1);
            end else begin
                exp_e = sb.pop_front();
                chk("evt", {evt_if.evt_ext, evt_if.evt_break, evt_if.evt_code}, exp_e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] codes [6];
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};

        // Reset state
        evt_if.evt_ready = 1'b1;
        do_reset();
        chk("rst_valid", evt_if.evt_valid, 0);
        chk("rst_code", {evt_if.evt_ext, evt_if.evt_break, evt_if.evt_code}, 0);
        chk("rst_key_down", key_down, 0);
        chk("rst_held", {held_ext, held_code}, 0);
        chk("rst_press", press_count, 0);
        chk("rst_ovf", overflow, 0);

        // Make then break
        expect_evt(8'h1C, 1'b0, 1'b0);
        send(8'h1C);
        chk("t1_key_down_make", key_down, 1);
        chk("t1_press_make", press_count, 1);
        expect_evt(8'h1C, 1'b1, 1'b0);
        send(8'hF0);
        send(8'h1C);
        chk("t1_key_down_brk", key_down, 0);
        chk("t1_held_code", held_code, 8'h1C);
        chk("t1_press_brk", press_count, 1);
        drain("t1");

        // Typematic repeat
        do_reset();
        for (int i = 0; i < 3; i++) begin
            expect_evt(8'h1C, 1'b0, 1'b0);
            send(8'h1C);
        end
        chk("t2_press_rep", press_count, 1);
        expect_evt(8'h1C, 1'b1, 1'b0);
        send(8'hF0);
        send(8'h1C);
        chk("t2_press", press_count, 1);
        chk("t2_key_down", key_down, 0);
        drain("t2");

        // Extended prefix
        do_reset();
        expect_evt(8'h75, 1'b0, EXT_ON);
        send(8'hE0);
        send(8'h75);
        chk("t3_held", {held_ext, held_code}, {EXT_ON, 8'h75});
        chk("t3_key_down_make", key_down, 1);
        expect_evt(8'h75, 1'b1, EXT_ON);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        chk("t3_key_down_brk", key_down, 0);
        chk("t3_held_ext", held_ext, EXT_ON);
        chk("t3_press", press_count, 1);
        drain("t3");

        // Overflow with a stalled consumer
        do_reset();
        evt_if.evt_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < FIFO_DEPTH) expect_evt(codes[i], 1'b0, 1'b0);
            send(codes[i]);
            if (i == FIFO_DEPTH - 1) chk("t4_ovf_at_full", overflow, 0);
        end
        chk("t4_ovf", overflow, 1);
        chk("t4_head_valid", evt_if.evt_valid, 1);
        chk("t4_head_code", evt_if.evt_code, 8'h15);
        chk("t4_press", press_count, 6);
        drain("t4");
        chk("t4_ovf_sticky", overflow, 1);

        // Push and pop together while full
        do_reset();
        evt_if.evt_ready = 1'b0;
        expect_evt(8'h16, 1'b0, 1'b0); send(8'h16);
        expect_evt(8'h1E, 1'b0, 1'b0); send(8'h1E);
        expect_evt(8'h26, 1'b0, 1'b0); send(8'h26);
        expect_evt(8'h25, 1'b0, 1'b0); send(8'h25);
        chk("t5_ovf_full", overflow, 0);
        expect_evt(8'h3C, 1'b0, 1'b0);
        evt_if.evt_ready = 1'b1;
        send(8'h3C);
        evt_if.evt_ready = 1'b0;
        chk("t5_ovf", overflow, 0);
        chk("t5_head_code", evt_if.evt_code, 8'h1E);
        drain("t5");
        chk("t5_ovf_end", overflow, 0);

        // Reset between prefix and code
        do_reset();
        send(8'hF0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6_valid_after_rst", evt_if.evt_valid, 0);
        expect_evt(8'h1C, 1'b0, 1'b0);
        send(8'h1C);
        chk("t6_press", press_count, 1);
        chk("t6_key_down", key_down, 1);
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kbd_event_ctrl.md
# kbd_event_ctrl

Sequences the raw scan-code byte stream from the PS/2 receiver into discrete key events: make and break, with optional extended-prefix decoding. Queues events for a downstream consumer over a valid/ready handshake. Tracks the currently held key and counts distinct presses for the status and seven-segment display logic. Sits between the PS/2 receiver and any keyboard consumer.

## Interface
- FIFO_DEPTH, 4, event queue depth; power of two, 2..16
- CNT_W, 8, press counter width
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- byte_valid  in  1  one-cycle strobe per accepted PS/2 frame
- byte_data  in  8  scan-code byte; qualified by byte_valid
- evt_valid  out  1  queue head holds an event
- evt_ready  in  1  consumer accepts head when evt_valid & evt_ready
- evt_code  out  8  head event scan code (prefixes stripped)
- evt_break  out  1  head event is a release
- evt_ext  out  1  head event carried the E0 prefix
- key_down  out  1  a key is currently held
- held_code  out  8  code of held key; last released code when key_down=0
- held_ext  out  1  extended flag of held key
- press_count  out  CNT_W  number of distinct presses, wraps modulo 2^CNT_W
- overflow  out  1  sticky: an event was dropped because the queue was full

## Operation
- Parser FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen). Transitions occur only on byte_valid.
- IDLE: F0 -> BRK; E0 -> EXT; other byte X -> emit make(X, ext=0) and stay in IDLE.
- BRK: F0 -> BRK; E0 -> EXT, which discards the pending break; other byte X -> emit break(X, ext=0) and go to IDLE.
- EXT: F0 -> EXT_BRK; E0 -> EXT; other byte X -> emit make(X, ext=1) and go to IDLE.
- EXT_BRK: F0 -> EXT_BRK; E0 -> EXT; other byte X -> emit break(X, ext=1) and go to IDLE.
- Held-key update on a make event:
  - If key_down=0, or {ext,code} differs from {held_ext,held_code}: press_count += 1, key_down <= 1, held <= {ext,code}.
  - Otherwise (typematic repeat): no change.
- Held-key update on a break event:
  - If {ext,code} equals held while key_down=1: key_down <= 0.
  - Otherwise: ignored. held_code and held_ext are never changed by a break.
- Held-key tracking updates regardless of queue state.
- Queue behaviour:
  - Every emitted event is pushed. Repeats are pushed too.
  - If full, the push is dropped and overflow is set. overflow is cleared only by rst.
  - Push and pop in the same cycle while full: the pop frees the slot and the push is accepted; no overflow.
  - Pop when empty: no effect.
- Reset values: FSM state IDLE, queue empty, evt_valid=0, evt_code=0, evt_break=0, evt_ext=0, key_down=0, held_code=0, held_ext=0, press_count=0, overflow=0.
- Reset asserted mid-sequence (for example after F0) discards the partial prefix and all queued events.

## Timing
- A byte_valid at cycle N that completes an event produces:
  - evt_valid, evt_code, evt_break, evt_ext visible at N+1 when the queue was empty;
  - key_down, held_code, held_ext, press_count updated at N+1.
- Queue is first-word-fall-through. The head is stable while evt_valid=1 and evt_ready=0. The next entry appears the cycle after a pop.
- Sustained throughput is one event per cycle; byte_valid may be asserted on consecutive cycles.
- overflow rises at N+1 after the dropped push.

## Configuration
- KBD_EXT_EN defined: E0 handling as above; states EXT and EXT_BRK exist.
- KBD_EXT_EN undefined: EXT and EXT_BRK are not built.
  - E0 bytes are consumed silently with no state change.
  - evt_ext and held_ext are tied to 0.
  - Matching for held-key tracking compares code only.

## Structure
- Package kbd_pkg holds:
  - constants SC_BREAK=8'hF0 and SC_EXT=8'hE0;
  - parser state enum;
  - event record {ext, brk, code[7:0]}, 10 bits wide.
- Sub-module kbd_evt_fifo: a synchronous FIFO parameterised by depth and width. It has push/full, pop/empty and a combinational head output.
- Parser FSM and held-key logic live in kbd_event_ctrl.

## Test plan
- Reset, then bytes 1C, F0, 1C with evt_ready=1 -> events make(1C,0) and break(1C,0); press_count=1; key_down 1 then 0; held_code=1C.
- Bytes 1C ×3 (typematic), then F0 1C -> four events; press_count=1.
- Bytes E0 75, E0 F0 75 with KBD_EXT_EN -> make(75,1) and break(75,1); held_ext=1. Without the macro -> make(75,0) and break(75,0); evt_ext=0.
- evt_ready=0, FIFO_DEPTH=4, six make codes -> four queued and overflow=1. Then drain -> the first four codes come out in order.
- Queue full, with byte_valid completing an event and evt_ready=1 in the same cycle -> push accepted; overflow stays 0.
- Bytes F0, then rst, then 1C -> make(1C,0) rather than a break; press_count=1.
